// File: rtl/inst_assembler.sv
// Assembles 1..3 byte instructions from a prefetch-queue byte stream into a
// ready/valid instruction slot. Define INST_ASM_PC_TRACK_EN to track opcode addresses.
module inst_assembler #(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      q_data,
  input  logic            q_empty,
  output logic            q_pull,
  input  logic [1:0]      len_in,
  input  logic            flush,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_in,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [7:0]      inst_op,
  output logic [7:0]      inst_lo,
  output logic [7:0]      inst_hi,
  output logic [1:0]      inst_len,
  output logic [PC_W-1:0] inst_pc
);

  typedef enum logic [1:0] {
    ST_OP = 2'd0,
    ST_LO = 2'd1,
    ST_HI = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic [7:0] lo_q, lo_d;
  logic [1:0] len_q, len_d;

  logic       inst_valid_q, inst_valid_d;
  logic [7:0] inst_op_q, inst_op_d;
  logic [7:0] inst_lo_q, inst_lo_d;
  logic [7:0] inst_hi_q, inst_hi_d;
  logic [1:0] inst_len_q, inst_len_d;

  logic [1:0] len_eff;
  logic       final_byte;
  logic       slot_free;
  logic       pull;

  assign len_eff   = (len_in == 2'd0) ? 2'd1 : len_in;
  assign slot_free = !inst_valid_q || inst_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    final_byte = 1'b1;
    unique case (state_q)
      ST_OP:   final_byte = (len_eff == 2'd1);
      ST_LO:   final_byte = (len_q == 2'd2);
      ST_HI:   final_byte = 1'b1;
      default: final_byte = 1'b1;
    endcase
  end

  // The last byte may only be taken when the output slot can accept it.
  assign pull   = !reset && !q_empty && !flush && (!final_byte || slot_free);
  assign q_pull = pull;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    lo_d         = lo_q;
    len_d        = len_q;
    inst_valid_d = inst_valid_q;
    inst_op_d    = inst_op_q;
    inst_lo_d    = inst_lo_q;
    inst_hi_d    = inst_hi_q;
    inst_len_d   = inst_len_q;

    if (flush) begin
      state_d      = ST_OP;
      op_d         = 8'h00;
      lo_d         = 8'h00;
      len_d        = 2'd0;
      inst_valid_d = 1'b0;
    end else begin
      if (inst_valid_q && inst_ready) begin
        inst_valid_d = 1'b0;
      end
      if (pull) begin
        unique case (state_q)
          ST_OP: begin
            op_d    = q_data;
            lo_d    = 8'h00;
            len_d   = len_eff;
            state_d = (len_eff == 2'd1) ? ST_OP : ST_LO;
            if (final_byte) begin
              inst_op_d  = q_data;
              inst_lo_d  = 8'h00;
              inst_hi_d  = 8'h00;
              inst_len_d = 2'd1;
            end
          end
          ST_LO: begin
            lo_d    = q_data;
            state_d = (len_q == 2'd3) ? ST_HI : ST_OP;
            if (final_byte) begin
              inst_op_d  = op_q;
              inst_lo_d  = q_data;
              inst_hi_d  = 8'h00;
              inst_len_d = 2'd2;
            end
          end
          ST_HI: begin
            state_d    = ST_OP;
            inst_op_d  = op_q;
            inst_lo_d  = lo_q;
            inst_hi_d  = q_data;
            inst_len_d = 2'd3;
          end
          default: state_d = ST_OP;
        endcase
        // A final pull in the same cycle as a transfer keeps the slot full.
        if (final_byte) begin
          inst_valid_d = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_OP;
      op_q         <= 8'h00;
      lo_q         <= 8'h00;
      len_q        <= 2'd0;
      inst_valid_q <= 1'b0;
      inst_op_q    <= 8'h00;
      inst_lo_q    <= 8'h00;
      inst_hi_q    <= 8'h00;
      inst_len_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      lo_q         <= lo_d;
      len_q        <= len_d;
      inst_valid_q <= inst_valid_d;
      inst_op_q    <= inst_op_d;
      inst_lo_q    <= inst_lo_d;
      inst_hi_q    <= inst_hi_d;
      inst_len_q   <= inst_len_d;
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst_op    = inst_op_q;
  assign inst_lo    = inst_lo_q;
  assign inst_hi    = inst_hi_q;
  assign inst_len   = inst_len_q;

`ifdef INST_ASM_PC_TRACK_EN
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_op_q, pc_op_d;
  logic [PC_W-1:0] inst_pc_q, inst_pc_d;

  always_comb begin
    pc_op_d   = pc_op_q;
    inst_pc_d = inst_pc_q;
    if (pull && (state_q == ST_OP)) begin
      pc_op_d = pc_q;
    end
    if (pull && final_byte) begin
      inst_pc_d = (state_q == ST_OP) ? pc_q : pc_op_q;
    end
    // A redirect wins over the post-pull increment, with or without flush.
    if (pc_load) begin
      pc_d = pc_in;
    end else if (pull) begin
      pc_d = pc_q + PC_W'(1);
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      pc_op_q   <= '0;
      inst_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      pc_op_q   <= pc_op_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  assign inst_pc = inst_pc_q;
`else
  logic unused_pc;
  assign unused_pc = &{1'b0, pc_load, pc_in};
  assign inst_pc   = '0;
`endif

endmodule

// File: tb/tb_inst_assembler.sv
// Directed self-checking bench for inst_assembler; a byte array stands in for
// the prefetch queue and pops whenever the DUT asserts q_pull.
module tb_inst_assembler;
  localparam int PC_W = 16;

  logic            clk;
  logic            reset;
  logic [7:0]      q_data;
  logic            q_empty;
  logic            q_pull;
  logic [1:0]      len_in;
  logic            flush;
  logic            pc_load;
  logic [PC_W-1:0] pc_in;
  logic            inst_valid;
  logic            inst_ready;
  logic [7:0]      inst_op;
  logic [7:0]      inst_lo;
  logic [7:0]      inst_hi;
  logic [1:0]      inst_len;
  logic [PC_W-1:0] inst_pc;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] qmem [0:63];
  logic [1:0] lmem [0:63];
  int rd_ptr = 0;
  int wr_ptr = 0;

  assign q_data  = qmem[rd_ptr];
  assign len_in  = lmem[rd_ptr];
  assign q_empty = (rd_ptr >= wr_ptr);

  inst_assembler #(.PC_W(PC_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .q_data     (q_data),
    .q_empty    (q_empty),
    .q_pull     (q_pull),
    .len_in     (len_in),
    .flush      (flush),
    .pc_load    (pc_load),
    .pc_in      (pc_in),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_op    (inst_op),
    .inst_lo    (inst_lo),
    .inst_hi    (inst_hi),
    .inst_len   (inst_len),
    .inst_pc    (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (q_pull) rd_ptr <= rd_ptr + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] epc(input logic [15:0] p);
`ifdef INST_ASM_PC_TRACK_EN
    return {16'h0000, p};
`else
    return 32'h0 & {16'h0000, p};
`endif
  endfunction

  task automatic push(input logic [7:0] b, input logic [1:0] l);
    qmem[wr_ptr] = b;
    lmem[wr_ptr] = l;
    wr_ptr++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_inst(input string tag, input logic [7:0] op, input logic [7:0] lo,
                          input logic [7:0] hi, input logic [1:0] len, input logic [15:0] pc);
    check({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
    check({tag, "_op"},    {24'b0, inst_op},    {24'b0, op});
    check({tag, "_lo"},    {24'b0, inst_lo},    {24'b0, lo});
    check({tag, "_hi"},    {24'b0, inst_hi},    {24'b0, hi});
    check({tag, "_len"},   {30'b0, inst_len},   {30'b0, len});
    check({tag, "_pc"},    {16'b0, inst_pc},    epc(pc));
  endtask

  initial begin
    logic [7:0] ops37 [0:2];
    ops37[0] = 8'hEA; ops37[1] = 8'hE8; ops37[2] = 8'hCA;

    reset = 1'b0; flush = 1'b0; pc_load = 1'b0; pc_in = '0; inst_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_op",    {24'b0, inst_op},    32'd0);
    check("rst_len",   {30'b0, inst_len},   32'd0);
    check("rst_pc",    {16'b0, inst_pc},    32'd0);
    check("rst_pull",  {31'b0, q_pull},     32'd0);
    cyc();
    reset = 1'b0;

    // Two-byte instruction after a PC load
    pc_load = 1'b1; pc_in = 16'h0200; inst_ready = 1'b1;
    cyc();
    pc_load = 1'b0;
    push(8'hA9, 2'd2); push(8'h05, 2'd0);
    #1 check("len2_pull_op", {31'b0, q_pull}, 32'd1);
    cyc();
    check("len2_mid_valid", {31'b0, inst_valid}, 32'd0);
    check("len2_pull_lo",   {31'b0, q_pull},     32'd1);
    cyc();
    chk_inst("len2", 8'hA9, 8'h05, 8'h00, 2'd2, 16'h0200);
    cyc();
    check("len2_clear", {31'b0, inst_valid}, 32'd0);

    // Back-to-back single-byte instructions
    pc_load = 1'b1; pc_in = 16'h0200;
    cyc();
    pc_load = 1'b0;
    push(8'hEA, 2'd1); push(8'hE8, 2'd1); push(8'hCA, 2'd1);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2b_pull%0d", i), {31'b0, q_pull}, 32'd1);
      cyc();
      chk_inst($sformatf("b2b%0d", i), ops37[i], 8'h00, 8'h00, 2'd1, 16'h0200 + 16'(i));
    end
    check("b2b_nopull", {31'b0, q_pull}, 32'd0);
    cyc();
    check("b2b_clear", {31'b0, inst_valid}, 32'd0);

    // Final byte held back while the slot is occupied
    inst_ready = 1'b0;
    push(8'h1A, 2'd1); push(8'h4C, 2'd3); push(8'h34, 2'd0); push(8'h12, 2'd0);
    #1 check("bp_pull_1a", {31'b0, q_pull}, 32'd1);
    cyc();
    chk_inst("bp_held", 8'h1A, 8'h00, 8'h00, 2'd1, 16'h0203);
    cyc();
    cyc();
    check("bp_hold_nopull", {31'b0, q_pull}, 32'd0);
    cyc();
    check("bp_hold_nopull2", {31'b0, q_pull}, 32'd0);
    chk_inst("bp_stable", 8'h1A, 8'h00, 8'h00, 2'd1, 16'h0203);
    inst_ready = 1'b1;
    #1 check("bp_release_pull", {31'b0, q_pull}, 32'd1);
    cyc();
    chk_inst("bp_len3", 8'h4C, 8'h34, 8'h12, 2'd3, 16'h0204);
    cyc();
    check("bp_clear", {31'b0, inst_valid}, 32'd0);

    // Queue underrun mid-instruction
    push(8'hAD, 2'd3);
    #1;
    cyc();
    repeat (5) cyc();
    check("empty_nopull", {31'b0, q_pull},     32'd0);
    check("empty_valid",  {31'b0, inst_valid}, 32'd0);
    push(8'h00, 2'd0); push(8'h10, 2'd0);
    #1 check("empty_resume_pull", {31'b0, q_pull}, 32'd1);
    cyc();
    cyc();
    chk_inst("empty_len3", 8'hAD, 8'h00, 8'h10, 2'd3, 16'h0207);
    cyc();

    // Flush with redirect while waiting for the high operand
    push(8'h4C, 2'd3); push(8'h34, 2'd0);
    #1;
    cyc();
    cyc();
    flush = 1'b1; pc_load = 1'b1; pc_in = 16'h8000;
    push(8'h99, 2'd1);
    #1 check("flush_nopull", {31'b0, q_pull}, 32'd0);
    cyc();
    check("flush_valid", {31'b0, inst_valid}, 32'd0);
    flush = 1'b0; pc_load = 1'b0;
    #1 check("flush_after_pull", {31'b0, q_pull}, 32'd1);
    cyc();
    chk_inst("flush_new", 8'h99, 8'h00, 8'h00, 2'd1, 16'h8000);
    cyc();

    // PC wrap
    pc_load = 1'b1; pc_in = 16'hFFFF;
    cyc();
    pc_load = 1'b0;
    push(8'h77, 2'd1); push(8'h78, 2'd1);
    #1;
    cyc();
    chk_inst("wrap_ffff", 8'h77, 8'h00, 8'h00, 2'd1, 16'hFFFF);
    cyc();
    chk_inst("wrap_0000", 8'h78, 8'h00, 8'h00, 2'd1, 16'h0000);
    cyc();

    // Asynchronous reset in the middle of a three-byte instruction
    push(8'hAD, 2'd3); push(8'h11, 2'd0);
    #1;
    cyc();
    cyc();
    #2 reset = 1'b1;
    push(8'h22, 2'd0);
    #1;
    check("arst_pull",  {31'b0, q_pull},     32'd0);
    check("arst_valid", {31'b0, inst_valid}, 32'd0);
    check("arst_op",    {24'b0, inst_op},    32'd0);
    check("arst_lo",    {24'b0, inst_lo},    32'd0);
    check("arst_hi",    {24'b0, inst_hi},    32'd0);
    check("arst_len",   {30'b0, inst_len},   32'd0);
    check("arst_pc",    {16'b0, inst_pc},    32'd0);
    cyc();
    check("arst_pull_hold", {31'b0, q_pull}, 32'd0);
    reset = 1'b0;
    #1 check("arst_release_pull", {31'b0, q_pull}, 32'd1);
    cyc();
    chk_inst("arst_restart", 8'h22, 8'h00, 8'h00, 2'd1, 16'h0000);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inst_assembler.md
INST_ASSEMBLER -- requirements
Module: inst_assembler

Interface
REQ-001 Parameter: PC_W, default 16, program-counter width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 q_data  input  8  byte at prefetch-queue head.
REQ-005 q_empty  input  1  queue holds no bytes; q_data invalid.
REQ-006 q_pull  output  1  pop queue head this cycle (combinational).
REQ-007 len_in  input  2  length decoded from q_data when it is an opcode; 1..3.
REQ-008 flush  input  1  branch/redirect; discard partial and pending instruction.
REQ-009 pc_load  input  1  load PC counter from pc_in.
REQ-010 pc_in  input  PC_W  redirect address.
REQ-011 inst_valid  output  1  assembled instruction held on outputs.
REQ-012 inst_ready  input  1  consumer accepts; transfer on inst_valid && inst_ready.
REQ-013 inst_op / inst_lo / inst_hi  output  8 each  opcode, operand low, operand high.
REQ-014 inst_len  output  2  instruction length 1..3.
REQ-015 inst_pc  output  PC_W  address of the opcode byte.

Function
REQ-016 FSM states: OP (expect opcode), LO (expect operand low), HI (expect operand high).
REQ-017 Pull in OP: latch q_data as opcode, latch len_in (0 treated as 1), capture PC as opcode address; next state LO if len>1, else stay OP.
REQ-018 Pull in LO: latch operand low; next HI if len==3, else OP.
REQ-019 Pull in HI: latch operand high; next OP.
REQ-020 Final byte = opcode of len 1, LO byte of len 2, HI byte of len 3.
REQ-021 q_pull = !q_empty && !flush && (non-final byte || slot free); slot free = !inst_valid || inst_ready.
REQ-022 Final-byte pull: outputs load the assembled instruction, inst_valid=1 next cycle; unused operand outputs = 0x00.
REQ-023 Latency: inst_valid rises the cycle after the final pull; sustained throughput 1 byte/cycle, a len-1 stream yields 1 instruction/cycle.
REQ-024 inst_valid clears after a transfer unless a new final pull happens that same cycle (back-to-back).
REQ-025 Outputs stay stable while inst_valid && !inst_ready.
REQ-026 q_empty mid-instruction: hold state and partial bytes, no pull, no timeout.
REQ-027 flush: q_pull=0 that cycle; next cycle state=OP, inst_valid=0, partial bytes discarded.
REQ-028 flush with valid && ready in the same cycle counts as accepted, then clears.
REQ-029 PC counter increments by 1 on every pull and wraps modulo 2^PC_W (0xFFFF -> 0x0000).
REQ-030 pc_load loads pc_in and overrides the increment; pc_load is independent of flush.

Reset
REQ-031 Reset asserted: state=OP, inst_valid=0, all instruction outputs and PC counter = 0, partial bytes cleared, immediately and asynchronously.
REQ-032 Reset during assembly discards the partial instruction.
REQ-033 q_pull=0 while reset asserted.

Configuration
REQ-034 Macro INST_ASM_PC_TRACK_EN defined: PC counter, pc_load/pc_in and inst_pc behave per REQ-017, REQ-029, REQ-030.
REQ-035 Macro undefined: no PC register; inst_pc tied to 0; pc_load/pc_in ignored; all other behaviour identical.

Verification
REQ-036 pc_load pc_in=0x0200, queue A9 05 (len 2), ready=1 -> two pulls; inst_valid 1 cycle with op=A9 lo=05 hi=00 len=2 pc=0x0200.
REQ-037 Queue EA E8 CA (len 1 each), ready=1 -> q_pull=1 three consecutive cycles; three back-to-back valid instructions, pc 0x0200/0x0201/0x0202.
REQ-038 Queue 4C 34 12 (len 3), inst_ready=0 -> 4C and 34 pulled; 12 not pulled while the previous instruction is held; raising ready pulls 12; instruction op=4C lo=34 hi=12.
REQ-039 q_empty after AD, then 00 10 arrive 5 cycles later -> state holds in LO; instruction op=AD lo=00 hi=10 len=3 completes.
REQ-040 flush with pc_load pc_in=0x8000 mid len-3 assembly -> partial dropped, inst_valid=0, next opcode carries pc=0x8000; pc 0xFFFF followed by a pull wraps to 0x0000.
REQ-041 Reset pulse asynchronous to clk mid-instruction -> outputs 0 immediately, q_pull=0, assembly restarts in OP after release.
